l2_icache_resp: RTL and testbench
=================================

// Module: l2_icache_resp
// PURPOSE
//  L2-side responder for I-Cache refill requests. Samples the I-Cache miss request
//  (irq + 28-bit block address) and grants the L2 port via ic_en. Looks up a
//  direct-mapped L2 held in external sync-read tag/data RAMs. On an L2 miss it
//  refills from main memory, then returns the 128-bit block (l2_rdy) and pulses
//  complete once the L1 write has been given a cycle.
// PARAMETERS
//  L2_IDX_W  9  L2 set-index width; tag width TAG_W = 28 - L2_IDX_W (default 19)
// PORTS
//  clk          in   1          clock
//  rst          in   1          synchronous, active-high reset
//  irq          in   1          I-Cache refill request, level, held until complete
//  l2_addr      in   28         I-Cache block address (word addr [29:2])
//  dc_busy      in   1          D-side currently owns L2; blocks new IC grants
//  ic_en        out  1          L2 granted to I-Cache
//  l2_rdy       out  1          block valid on data_wd_l2 (1-cycle pulse)
//  data_wd_l2   out  128        refill block to I-Cache
//  complete     out  1          L1 write finished (1-cycle pulse)
//  l2_index     out  L2_IDX_W   L2 tag/data RAM index
//  l2_tag_rd    in   TAG_W+1    {valid,tag}, valid the cycle after l2_index set
//  l2_data_rd   in   128        L2 data, same timing as l2_tag_rd
//  l2_we        out  1          L2 tag+data write enable
//  l2_tag_wd    out  TAG_W+1    {1'b1, addr_q[27:L2_IDX_W]}
//  l2_data_wd   out  128        fill data (= buf_q)
//  mem_req      out  1          memory read request, level, held until mem_rdy
//  mem_addr     out  28         memory block address (= addr_q)
//  mem_rdy      in   1          memory data valid (1-cycle pulse)
//  mem_rd       in   128        memory block data
// BEHAVIOUR
//  Reset: state=IDLE. ic_en, l2_rdy, complete, l2_we, mem_req = 0.
//   data_wd_l2, buf_q, addr_q, l2_index = 0.
//  Regs: addr_q[27:0] latched at grant; buf_q[127:0] drives data_wd_l2 and
//   l2_data_wd. buf_q holds its value until the next capture.
//  FSM:
//   IDLE: ic_en = ~dc_busy; l2_index = l2_addr[L2_IDX_W-1:0].
//    irq & ~dc_busy -> addr_q <= l2_addr, go LOOKUP. Otherwise stay.
//   LOOKUP: ic_en=1. hit = l2_tag_rd[TAG_W] & (l2_tag_rd[TAG_W-1:0] == addr_q[27:L2_IDX_W]).
//    hit -> buf_q <= l2_data_rd, go RESP. miss -> go MEM.
//   MEM: mem_req=1, mem_addr=addr_q. mem_rdy -> buf_q <= mem_rd, go FILL.
//   FILL: l2_we=1 for exactly 1 cycle, index = addr_q index -> RESP.
//   RESP: l2_rdy=1 for 1 cycle -> DONE.
//   DONE: complete=1 for 1 cycle -> IDLE.
//  ic_en stays 1 from LOOKUP through DONE, regardless of dc_busy.
//  Latency, irq sampled to l2_rdy: hit = 2 cycles; miss = 3 + memory wait cycles.
//  dc_busy only blocks a grant taken in IDLE; it has no effect mid-transaction.
//  irq is ignored after grant: a transaction always runs to DONE even if irq drops.
//  irq still high in the cycle after DONE starts a new transaction. Legal: the
//   I-Cache drops irq on complete.
//  mem_rdy outside MEM is ignored. Reset mid-operation -> IDLE next cycle;
//   mem_req drops and no partial L2 write occurs.
// CONFIGURATION
//  L2_PERF_EN defined: adds outputs hit_cnt[31:0] and miss_cnt[31:0].
//   Each is incremented in LOOKUP on hit / miss respectively.
//   Both saturate at 32'hFFFF_FFFF; reset to 0.
//  L2_PERF_EN undefined: neither port nor counter exists; behaviour otherwise identical.
// TESTING
//  1 Reset, irq=0 -> ic_en=1, all pulses 0, mem_req=0 for 10 cycles.
//  2 Preload idx 0x012 with {1,19'h00ABC} and data D; irq, l2_addr=28'h0157812
//    -> l2_rdy 2 cycles later, data_wd_l2=D, complete next cycle, mem_req never high.
//  3 Miss at 28'h0ABCDE1, mem_rdy after 5 cycles with M -> mem_addr=28'h0ABCDE1;
//    l2_we 1 cycle with l2_tag_wd={1,addr[27:9]}, data M; l2_rdy next cycle, then complete.
//  4 dc_busy=1 with irq=1 for 4 cycles -> ic_en=0, no LOOKUP;
//    dc_busy falls -> grant next edge.
//  5 rst pulsed during MEM -> mem_req=0 the next cycle, l2_we never pulses,
//    FSM in IDLE.
//  6 L2_PERF_EN: 3 hits + 2 misses -> hit_cnt=3, miss_cnt=2;
//    force hit_cnt=32'hFFFFFFFF, then 1 hit -> hit_cnt stays 32'hFFFFFFFF.

Source files
------------

// File: rtl/l2_icache_resp_if.sv
// Bundle of the I-Cache request, L2 tag/data RAM and main-memory signals of l2_icache_resp.
// slave is the responder's view, master is the view of the blocks around it.
interface l2_icache_resp_if #(
  parameter int L2_IDX_W = 9
);
  localparam int TAG_W = 28 - L2_IDX_W;

  logic                irq;
  logic [27:0]         l2_addr;
  logic                dc_busy;
  logic                ic_en;
  logic                l2_rdy;
  logic [127:0]        data_wd_l2;
  logic                complete;
  logic [L2_IDX_W-1:0] l2_index;
  logic [TAG_W:0]      l2_tag_rd;
  logic [127:0]        l2_data_rd;
  logic                l2_we;
  logic [TAG_W:0]      l2_tag_wd;
  logic [127:0]        l2_data_wd;
  logic                mem_req;
  logic [27:0]         mem_addr;
  logic                mem_rdy;
  logic [127:0]        mem_rd;

  modport slave (
    input  irq, l2_addr, dc_busy, l2_tag_rd, l2_data_rd, mem_rdy, mem_rd,
    output ic_en, l2_rdy, data_wd_l2, complete, l2_index, l2_we, l2_tag_wd,
           l2_data_wd, mem_req, mem_addr
  );

  modport master (
    output irq, l2_addr, dc_busy, l2_tag_rd, l2_data_rd, mem_rdy, mem_rd,
    input  ic_en, l2_rdy, data_wd_l2, complete, l2_index, l2_we, l2_tag_wd,
           l2_data_wd, mem_req, mem_addr
  );
endinterface

// File: rtl/l2_icache_resp.sv
// L2-side responder for I-Cache refills: direct-mapped L2 lookup, memory refill, block return.
// Define L2_PERF_EN to add saturating hit_cnt / miss_cnt outputs.
module l2_icache_resp #(
  parameter int L2_IDX_W = 9
) (
  input  logic            clk,
  input  logic            rst,
  l2_icache_resp_if.slave bus
`ifdef L2_PERF_EN
  ,
  output logic [31:0]     hit_cnt,
  output logic [31:0]     miss_cnt
`endif
);
  localparam int TAG_W = 28 - L2_IDX_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_MEM    = 3'd2,
    S_FILL   = 3'd3,
    S_RESP   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t       r_state;
  logic [27:0]  r_addr_q;
  logic [127:0] r_buf_q;
  logic         r_l2_rdy;
  logic         r_complete;
  logic         r_l2_we;
  logic         r_mem_req;

  logic         w_grant;
  logic         w_hit;
  logic         w_idle;

  assign w_idle  = (r_state == S_IDLE);
  assign w_grant = bus.irq & ~bus.dc_busy;
  assign w_hit   = bus.l2_tag_rd[TAG_W] &
                   (bus.l2_tag_rd[TAG_W-1:0] == r_addr_q[27:L2_IDX_W]);

  // Index follows the live request in IDLE so the sync-read RAM answers in LOOKUP.
  assign bus.l2_index   = w_idle ? bus.l2_addr[L2_IDX_W-1:0] : r_addr_q[L2_IDX_W-1:0];
  assign bus.ic_en      = ~w_idle | ~bus.dc_busy;
  assign bus.l2_rdy     = r_l2_rdy;
  assign bus.complete   = r_complete;
  assign bus.l2_we      = r_l2_we;
  assign bus.mem_req    = r_mem_req;
  assign bus.mem_addr   = r_addr_q;
  assign bus.data_wd_l2 = r_buf_q;
  assign bus.l2_data_wd = r_buf_q;
  assign bus.l2_tag_wd  = {1'b1, r_addr_q[27:L2_IDX_W]};

  // Transaction FSM; pulse outputs are loaded on the edge entering their state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr_q   <= 28'd0;
      r_buf_q    <= 128'd0;
      r_l2_rdy   <= 1'b0;
      r_complete <= 1'b0;
      r_l2_we    <= 1'b0;
      r_mem_req  <= 1'b0;
    end else begin
      r_l2_rdy   <= 1'b0;
      r_complete <= 1'b0;
      r_l2_we    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_addr_q <= bus.l2_addr;
            r_state  <= S_LOOKUP;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            r_buf_q   <= bus.l2_data_rd;
            r_l2_rdy  <= 1'b1;
            r_state   <= S_RESP;
          end else begin
            r_mem_req <= 1'b1;
            r_state   <= S_MEM;
          end
        end
        S_MEM: begin
          if (bus.mem_rdy) begin
            r_buf_q   <= bus.mem_rd;
            r_mem_req <= 1'b0;
            r_l2_we   <= 1'b1;
            r_state   <= S_FILL;
          end else begin
            r_state   <= S_MEM;
          end
        end
        S_FILL: begin
          r_l2_rdy <= 1'b1;
          r_state  <= S_RESP;
        end
        S_RESP: begin
          r_complete <= 1'b1;
          r_state    <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

`ifdef L2_PERF_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;

  // Saturating lookup outcome counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= 32'd0;
      r_miss_cnt <= 32'd0;
    end else if (r_state == S_LOOKUP) begin
      if (w_hit) begin
        if (r_hit_cnt != 32'hFFFF_FFFF) begin
          r_hit_cnt <= r_hit_cnt + 32'd1;
        end
      end else begin
        if (r_miss_cnt != 32'hFFFF_FFFF) begin
          r_miss_cnt <= r_miss_cnt + 32'd1;
        end
      end
    end
  end
`endif
endmodule

// File: tb/tb_l2_icache_resp.sv
// Scoreboard bench for l2_icache_resp: L2 RAM and memory models, reference cache model, monitor.
module tb_l2_icache_resp;
  localparam int IDX_W = 9;
  localparam int TAG_W = 28 - IDX_W;
  localparam int NSET  = 1 << IDX_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l2_icache_resp_if #(.L2_IDX_W(IDX_W)) bus ();
`ifdef L2_PERF_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  l2_icache_resp #(.L2_IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef L2_PERF_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  typedef struct {
    logic [27:0]  addr;
    logic [127:0] data;
    logic         hit;
    int unsigned  t_issue;
  } exp_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int          fixed_wait = 0;
  int          last_wait = 0;
  int          mem_cnt = 0;
  logic        prev_rdy = 1'b0;
  logic        prev_we = 1'b0;

  // Reference L2 contents: index -> tag / block, present only once filled.
  logic [TAG_W-1:0] ref_tag [int];
  logic [127:0]     ref_dat [int];
`ifdef L2_PERF_EN
  int m_hits = 0;
  int m_misses = 0;
`endif

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endfunction

  function automatic void chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic logic [127:0] mem_val(input logic [27:0] a);
    logic [31:0] m;
    m = {4'h0, a} * 32'd13;
    return {4'hA, a, 4'h5, ~a, m, 32'hC0DE_0000 ^ {4'h0, a}};
  endfunction

  // Direct-mapped cache rule: hit if the set holds this tag, otherwise fetch and install.
  function automatic exp_t model(input logic [27:0] a);
    exp_t e;
    int   idx;
    idx    = int'(a[IDX_W-1:0]);
    e.addr = a;
    e.hit  = ref_tag.exists(idx) && (ref_tag[idx] == a[27:IDX_W]);
    if (e.hit) begin
      e.data = ref_dat[idx];
    end else begin
      e.data       = mem_val(a);
      ref_tag[idx] = a[27:IDX_W];
      ref_dat[idx] = e.data;
    end
`ifdef L2_PERF_EN
    if (e.hit) m_hits++;
    else m_misses++;
`endif
    e.t_issue = 0;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // L2 tag/data RAM model with one-cycle synchronous read.
  logic [TAG_W:0]   ram_tag [0:NSET-1];
  logic [127:0]     ram_dat [0:NSET-1];
  logic             ram_clr;
  logic             pre_we;
  logic [IDX_W-1:0] pre_idx;
  logic [TAG_W:0]   pre_tag;
  logic [127:0]     pre_dat;

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < NSET; i++) begin
        ram_tag[i] <= '0;
        ram_dat[i] <= '0;
      end
    end else if (pre_we) begin
      ram_tag[pre_idx] <= pre_tag;
      ram_dat[pre_idx] <= pre_dat;
    end else if (bus.l2_we) begin
      ram_tag[bus.l2_index] <= bus.l2_tag_wd;
      ram_dat[bus.l2_index] <= bus.l2_data_wd;
    end
    bus.l2_tag_rd  <= ram_tag[bus.l2_index];
    bus.l2_data_rd <= ram_dat[bus.l2_index];
  end

  // Memory model: answers a request after 1..6 cycles; stray pulses when idle.
  always @(negedge clk) begin
    automatic int w;
    bus.mem_rdy <= 1'b0;
    if (bus.mem_req) begin
      if (mem_cnt == 0) begin
        w = (fixed_wait != 0) ? fixed_wait : int'($urandom_range(1, 6));
        last_wait <= w;
      end else begin
        w = mem_cnt;
      end
      if (w == 1) begin
        bus.mem_rdy <= 1'b1;
        bus.mem_rd  <= mem_val(bus.mem_addr);
        mem_cnt     <= 0;
      end else begin
        mem_cnt <= w - 1;
      end
    end else begin
      mem_cnt <= 0;
      if ($urandom_range(0, 7) == 0) begin
        bus.mem_rdy <= 1'b1;
        bus.mem_rd  <= {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  // Monitor: compares every DUT output event against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_req) begin
        chkb("mem_req_expected", sb_q.size() != 0, 1'b1);
        if (sb_q.size() != 0) begin
          chkb("mem_req_on_hit", sb_q[0].hit, 1'b0);
          chk("mem_addr", 128'(bus.mem_addr), 128'(sb_q[0].addr));
        end
      end
      if (bus.l2_we) begin
        chkb("l2_we_expected", sb_q.size() != 0, 1'b1);
        chkb("l2_we_single", prev_we, 1'b0);
        if (sb_q.size() != 0) begin
          chkb("l2_we_on_miss", sb_q[0].hit, 1'b0);
          chk("l2_tag_wd", 128'(bus.l2_tag_wd), 128'({1'b1, sb_q[0].addr[27:IDX_W]}));
          chk("l2_data_wd", bus.l2_data_wd, sb_q[0].data);
          chk("l2_we_index", 128'(bus.l2_index), 128'(sb_q[0].addr[IDX_W-1:0]));
        end
      end
      if (bus.l2_rdy) begin
        chkb("l2_rdy_expected", sb_q.size() != 0, 1'b1);
        if (sb_q.size() != 0) begin
          exp_t e;
          e = sb_q.pop_front();
          chk("data_wd_l2", bus.data_wd_l2, e.data);
          chki("latency", int'(cyc - e.t_issue), e.hit ? 2 : 3 + last_wait);
        end
      end
      if (bus.complete) begin
        chkb("complete_after_rdy", prev_rdy, 1'b1);
      end
    end
    prev_rdy <= bus.l2_rdy;
    prev_we  <= bus.l2_we;
  end

  task automatic wait_done(input bit busy_mid);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.complete && n < 60) begin
      chkb("ic_en_held", bus.ic_en, 1'b1);
      if (busy_mid) begin
        bus.dc_busy = 1'($urandom_range(0, 1));
        bus.irq     = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      n++;
    end
    chkb("complete_seen", bus.complete, 1'b1);
    chkb("ic_en_done", bus.ic_en, 1'b1);
    bus.irq     = 1'b0;
    bus.dc_busy = 1'b0;
  endtask

  task automatic run_txn(input logic [27:0] a, input int fw, input bit busy_mid);
    exp_t e;
    fixed_wait = fw;
    e = model(a);
    e.t_issue = cyc;
    sb_q.push_back(e);
    bus.l2_addr = a;
    bus.irq     = 1'b1;
    wait_done(busy_mid);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d;
    exp_t         e;
    int           n;
    logic [8:0]   pool_idx [4];
    rst = 1'b1; ram_clr = 1'b1; pre_we = 1'b0; pre_idx = '0; pre_tag = '0; pre_dat = '0;
    bus.irq = 1'b0; bus.dc_busy = 1'b0; bus.l2_addr = 28'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0; ram_clr = 1'b0;

    // Reset state with no request
    repeat (10) begin
      @(negedge clk);
      chkb("rst_ic_en", bus.ic_en, 1'b1);
      chkb("rst_l2_rdy", bus.l2_rdy, 1'b0);
      chkb("rst_complete", bus.complete, 1'b0);
      chkb("rst_l2_we", bus.l2_we, 1'b0);
      chkb("rst_mem_req", bus.mem_req, 1'b0);
    end
    chk("rst_data_wd_l2", bus.data_wd_l2, 128'd0);
    chk("rst_l2_index", 128'(bus.l2_index), 128'd0);

    // Preloaded hit
    d = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    pre_idx = 9'h012; pre_tag = {1'b1, 19'h00ABC}; pre_dat = d; pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
    ref_tag[18] = 19'h00ABC;
    ref_dat[18] = d;
    run_txn(28'h0157812, 0, 1'b0);

    // Miss with a five-cycle memory wait
    run_txn(28'h0ABCDE1, 5, 1'b0);
    run_txn(28'h0ABCDE1, 0, 1'b0);

    // D-side busy holds off the grant
    e = model(28'h0157812);
    bus.l2_addr = 28'h0157812; bus.irq = 1'b1; bus.dc_busy = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chkb("busy_ic_en", bus.ic_en, 1'b0);
    end
    e.t_issue = cyc;
    sb_q.push_back(e);
    bus.dc_busy = 1'b0;
    #1 chkb("busy_release_ic_en", bus.ic_en, 1'b1);
    wait_done(1'b0);
    @(negedge clk);

    // Random traffic over a few contended sets
    pool_idx[0] = 9'h012; pool_idx[1] = 9'h013; pool_idx[2] = 9'h100; pool_idx[3] = 9'h0AB;
    for (int i = 0; i < 40; i++) begin
      logic [18:0] t;
      t = ($urandom_range(0, 4) == 0) ? 19'h00ABC : 19'($urandom_range(0, 2));
      run_txn({t, pool_idx[$urandom_range(0, 3)]}, 0, 1'($urandom_range(0, 1)));
    end

    // Reset while waiting on memory
    fixed_wait = 6;
    e.addr = 28'hFFFFFFF; e.data = mem_val(28'hFFFFFFF); e.hit = 1'b0; e.t_issue = cyc;
    sb_q.push_back(e);
    bus.l2_addr = 28'hFFFFFFF; bus.irq = 1'b1;
    n = 0;
    while (!bus.mem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    chkb("rstmid_mem_req_up", bus.mem_req, 1'b1);
    @(negedge clk);
    rst = 1'b1; bus.irq = 1'b0;
    @(negedge clk);
    chkb("rstmid_mem_req_drop", bus.mem_req, 1'b0);
    chkb("rstmid_l2_we", bus.l2_we, 1'b0);
    rst = 1'b0; bus.dc_busy = 1'b1;
    #1 chkb("rstmid_idle", bus.ic_en, 1'b0);
    repeat (8) begin
      @(negedge clk);
      chkb("rstmid_no_we", bus.l2_we, 1'b0);
      chkb("rstmid_no_rdy", bus.l2_rdy, 1'b0);
    end
    bus.dc_busy = 1'b0;
    void'(sb_q.pop_front());
    fixed_wait = 0;
    @(negedge clk);

`ifdef L2_PERF_EN
    m_hits = 0; m_misses = 0;
    run_txn({19'h11111, 9'h1F0}, 0, 1'b0);
    run_txn({19'h11111, 9'h1F0}, 0, 1'b0);
    run_txn({19'h11111, 9'h1F0}, 0, 1'b0);
    run_txn({19'h22222, 9'h1F1}, 0, 1'b0);
    run_txn({19'h22222, 9'h1F1}, 0, 1'b0);
    chki("hit_cnt", int'(hit_cnt), 3);
    chki("miss_cnt", int'(miss_cnt), 2);
    chki("hit_cnt_model", int'(hit_cnt), m_hits);
    force dut.r_hit_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.r_hit_cnt;
    run_txn({19'h11111, 9'h1F0}, 0, 1'b0);
    chk("hit_cnt_sat", 128'(hit_cnt), 128'(32'hFFFF_FFFF));
    chki("miss_cnt_after_sat", int'(miss_cnt), 2);
`endif

    chki("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
